midi_uart_tx: RTL
=================

# midi_uart_tx

MIDI serial transmitter that drives the `midi_tx` input of the MT32-pi link. Bytes come from the core's MPU-401 UART-mode logic and pass through a small FIFO. They are serialized as 31250-baud 8N1 frames on `CLK_AUDIO`. A built-in "panic" sequencer can emit All-Notes-Off on all 16 channels, used when the MT32-pi mode or ROM changes or on core reset.

## Interface
Parameters:
- `CLK_HZ`, 24576000: frequency of `CLK_AUDIO` in Hz.
- `BAUD`, 31250: serial bit rate.
- `FIFO_AW`, 4: FIFO address width; depth = 2^FIFO_AW = 16 bytes.

Ports:
- `CLK_AUDIO`, in, 1: block clock.
- `reset`, in, 1: reset; synchronous, active-high; clock `CLK_AUDIO`.
- `din`, in, 8: byte to transmit.
- `wr`, in, 1: write strobe, one byte per cycle high.
- `panic`, in, 1: request the All-Notes-Off sequence; level sampled per cycle.
- `full`, out, 1: FIFO holds 2^FIFO_AW bytes.
- `empty`, out, 1: FIFO holds 0 bytes.
- `busy`, out, 1: a frame is on the line, FIFO is not empty, or a panic is pending or active.
- `panic_busy`, out, 1: a panic is pending or running.
- `overflow`, out, 1: sticky; a write was dropped.
- `midi_tx`, out, 1: serial line, idle high. Connects to the `midi_tx` input of the MT32-pi link.

## Operation
- Bit period: `DIV` = round(`CLK_HZ`/`BAUD`), which is 786 at defaults. Each bit is exactly `DIV` cycles. A frame is 10 bits: start bit (0), then 8 data bits LSB first, then stop bit (1), for 10*`DIV` cycles total.
- FIFO:
  - `wr` with `~full` stores `din`.
  - `wr` while `full` drops the byte and sets `overflow`. This holds even if a pop happens in the same cycle.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - Read and write pointers wrap modulo the depth. `full` and `empty` are derived from a count of width `FIFO_AW`+1.
- Transmit FSM states: IDLE, START, DATA, STOP.
  - IDLE: byte source available → load shift register, go to START.
  - START: `midi_tx`=0 for `DIV` cycles → DATA.
  - DATA: bit counter runs 0..7, shifting right each `DIV` cycles → STOP after bit 7.
  - STOP: `midi_tx`=1 for `DIV` cycles. If another byte is available on the last STOP cycle, load it and go to START, so frames run back-to-back with no idle gap. Otherwise go to IDLE.
- Byte source priority:
  - While a panic is running, bytes come only from the panic generator.
  - Otherwise bytes come from the FIFO.
- Panic:
  - A rising or high `panic` while `panic_busy`=0 sets pending, and `panic_busy` goes to 1 the next cycle.
  - `panic` while `panic_busy`=1 is ignored.
  - Pending becomes running at the next frame boundary: when the FSM is in IDLE, or on the last STOP cycle. A frame in progress is never truncated. FIFO content is not drained first.
  - The sequence is 48 bytes: for ch = 0..15, send {8'hB0|ch, 8'h7B, 8'h00}.
  - FIFO writes continue to be accepted during panic. FIFO bytes resume after the last panic byte with no gap.
  - `panic_busy` clears on the last cycle of the 48th stop bit.
- Reset, including mid-frame:
  - FIFO flushed, FSM to IDLE, panic cancelled.
  - Output values: `midi_tx`=1, `full`=0, `empty`=1, `busy`=0, `panic_busy`=0, `overflow`=0.

## Timing
- All outputs are registered.
- Latency, write to line: `wr` in cycle N with FIFO empty and FSM in IDLE.
  - `empty`=0 at N+1.
  - Pop and load happen at N+1.
  - `midi_tx` falls at N+2.
  - `empty` returns to 1 at N+2.
- Falling edge of start bit to rising edge of stop bit: 9*`DIV` cycles, i.e. 7074 at defaults.
- `full` and `empty` reflect the count after each cycle's push/pop, visible the next cycle.
- `overflow` sets the cycle after the dropped write.
- The `DIV` counter restarts at every bit boundary; there is no cumulative drift within a frame.

## Test plan
- Single byte: write 8'h90 with FSM idle → `midi_tx` low at N+2. The line shows bits 0,0,0,0,0,1,0,0,1,1, each 786 cycles. `busy` returns to 0 after 7860 cycles.
- Back-to-back: write 8'h90, 8'h3C, 8'h7F on consecutive cycles → three frames with no idle gap, total 23580 cycles from the first start bit. Decoded bytes match exactly.
- Overflow: with the line busy, write 18 bytes → 16 accepted, `full`=1, `overflow`=1. Exactly the first 16 bytes are transmitted. `overflow` stays set until reset.
- Panic mid-frame: pulse `panic` halfway through a frame of 8'hC0 while the FIFO holds 8'h45 → 8'hC0 completes. Next come 48 bytes B0 7B 00 … BF 7B 00, then 8'h45. `panic_busy` is 1 throughout.
- Panic re-trigger: assert `panic` again during the sequence → ignored, exactly 48 panic bytes are sent.
- Reset mid-frame: assert `reset` during DATA bit 3 with 5 bytes queued → `midi_tx`=1 on the next cycle, `empty`=1, `busy`=0. No further frames are sent until a new write.

Source files
------------

// File: rtl/midi_uart_tx.sv
// MIDI 8N1 serial transmitter with a byte FIFO and an All-Notes-Off panic sequencer.
// Frames run back-to-back; panic bytes take priority over the FIFO once the current frame ends.
module midi_uart_tx #(
  parameter int unsigned CLK_HZ  = 24576000,
  parameter int unsigned BAUD    = 31250,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic       CLK_AUDIO,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       panic,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       panic_busy,
  output logic       overflow,
  output logic       midi_tx
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned DW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0]      r_count;
  logic               r_full, r_empty, r_overflow, r_busy, r_panic_busy, r_tx;
  state_e             r_state;
  logic [DW-1:0]      r_div;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_pend, r_run, r_pdone;
  logic [3:0]         r_pch;
  logic [1:0]         r_pk;

  state_e        w_state_d;
  logic [DW-1:0] w_div_d;
  logic [2:0]    w_bit_d;
  logic [7:0]    w_shift_d, w_panic_byte, w_fifo_byte;
  logic          w_tx_d, w_pop, w_push, w_bit_end, w_load_pt, w_panic_src;
  logic          w_pend_d, w_run_d, w_pdone_d;
  logic [3:0]    w_pch_d;
  logic [1:0]    w_pk_d;
  logic [CW-1:0] w_count_d;

  assign w_bit_end    = (r_div == DW'(DIV - 1));
  assign w_push       = wr & ~r_full;
  assign w_load_pt    = (r_state == StIdle) | ((r_state == StStop) & w_bit_end);
  // A finished panic run hands the next load point back to the FIFO.
  assign w_panic_src  = r_pend | (r_run & ~r_pdone);
  assign w_panic_byte = (r_pk == 2'd0) ? {4'hB, r_pch} : (r_pk == 2'd1) ? 8'h7B : 8'h00;
  assign w_fifo_byte  = r_mem[r_rptr];
  assign w_count_d    = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_d = r_state;
    w_div_d   = w_bit_end ? '0 : r_div + DW'(1);
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_tx_d    = r_tx;
    w_pop     = 1'b0;
    w_pend_d  = r_pend | (panic & ~r_panic_busy);
    w_run_d   = r_run;
    w_pdone_d = r_pdone;
    w_pch_d   = r_pch;
    w_pk_d    = r_pk;
    unique case (r_state)
      StIdle: begin
        w_div_d = '0;
        w_tx_d  = 1'b1;
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_d = StData;
          w_bit_d   = 3'd0;
          w_tx_d    = r_shift[0];
        end
      end
      StData: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_d = StStop;
            w_tx_d    = 1'b1;
          end else begin
            w_bit_d   = r_bit + 3'd1;
            w_shift_d = {1'b0, r_shift[7:1]};
            w_tx_d    = r_shift[1];
          end
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_state_d = StIdle;
          w_tx_d    = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_load_pt) begin
      if (w_panic_src) begin
        w_shift_d = w_panic_byte;
        w_state_d = StStart;
        w_div_d   = '0;
        w_tx_d    = 1'b0;
        w_pend_d  = 1'b0;
        w_run_d   = 1'b1;
        if (r_pk == 2'd2) begin
          w_pk_d  = 2'd0;
          w_pch_d = r_pch + 4'd1;
          if (r_pch == 4'd15) w_pdone_d = 1'b1;
        end else begin
          w_pk_d = r_pk + 2'd1;
        end
      end else begin
        w_run_d   = 1'b0;
        w_pdone_d = 1'b0;
        if (!r_empty) begin
          w_pop     = 1'b1;
          w_shift_d = w_fifo_byte;
          w_state_d = StStart;
          w_div_d   = '0;
          w_tx_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_AUDIO) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge CLK_AUDIO) begin
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
      r_panic_busy <= 1'b0;
      r_tx         <= 1'b1;
      r_state      <= StIdle;
      r_div        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_pend       <= 1'b0;
      r_run        <= 1'b0;
      r_pdone      <= 1'b0;
      r_pch        <= '0;
      r_pk         <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
      if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
      if (wr && r_full) r_overflow <= 1'b1;
      r_count      <= w_count_d;
      r_full       <= (w_count_d == CW'(DEPTH));
      r_empty      <= (w_count_d == '0);
      r_busy       <= (w_state_d != StIdle) | (w_count_d != '0) | w_pend_d | w_run_d;
      r_panic_busy <= w_pend_d | w_run_d;
      r_tx         <= w_tx_d;
      r_state      <= w_state_d;
      r_div        <= w_div_d;
      r_bit        <= w_bit_d;
      r_shift      <= w_shift_d;
      r_pend       <= w_pend_d;
      r_run        <= w_run_d;
      r_pdone      <= w_pdone_d;
      r_pch        <= w_pch_d;
      r_pk         <= w_pk_d;
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign busy       = r_busy;
  assign panic_busy = r_panic_busy;
  assign overflow   = r_overflow;
  assign midi_tx    = r_tx;

endmodule
